// File: rtl/trig_counter_bidir.sv
`default_nettype none
// ============================================================================
// Module   : trig_counter_bidir
// Desc     : Edge-triggered up/down timer with limit register on a shared
//            bidirectional bus. Optional prescaler: define PRESCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module trig_counter_bidir #(
   parameter int WIDTH     = 8,
   parameter int PRESC_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   inout  wire  [WIDTH-1:0] data_io,
   input  logic             we,
   input  logic             ld,
   input  logic             trig,
   input  logic             stop,
   input  logic             dir,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count_o,
   output logic             busy,
   output logic             tc_pulse
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             dir_q, dir_d;
   logic             reload_q, reload_d;
   logic             tc_q, tc_d;

   logic             trig_s1_q, trig_s1_d;
   logic             trig_s2_q, trig_s2_d;
   logic             trig_d_q, trig_d_d;
   logic [1:0]       sync_vld_q, sync_vld_d;
   logic             arm_q, arm_d;

   logic             start;
   logic             step_en;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] term_val;

   // PRESC_DIV below 2 is not a legal configuration.
   if (PRESC_DIV < 2) begin : g_presc_div_illegal
   end

   assign data_io  = we ? count_q : {WIDTH{1'bz}};
   assign count_o  = count_q;
   assign busy     = (state_q == ST_RUN);
   assign tc_pulse = tc_q;

   // A trig level that was high across reset must be seen low by a valid
   // synchroniser output before an edge is accepted again.
   always_comb begin
      trig_s1_d  = trig;
      trig_s2_d  = trig_s1_q;
      trig_d_d   = trig_s2_q;
      sync_vld_d = {sync_vld_q[0], 1'b1};
      arm_d      = arm_q | (sync_vld_q[1] & ~trig_s2_q);
   end

   assign start = trig_s2_q & ~trig_d_q & arm_q;

   always_comb begin
      limit_d = limit_q;
      if (!we && ld) begin
         limit_d = data_io;
      end
   end

`ifdef PRESCALE_EN
   localparam int PW = $clog2(PRESC_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;

   assign step_en = (presc_q == PRESC_MAX);

   always_comb begin
      presc_d = '0;
      if (state_q == ST_RUN && state_d == ST_RUN && !start && !stop) begin
         presc_d = step_en ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   assign step_en = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      dir_d     = dir_q;
      reload_d  = reload_q;
      tc_d      = 1'b0;
      start_val = dir ? limit_q : '0;
      term_val  = dir_q ? '0 : limit_q;
      if (reload_q) begin
         step_val = dir_q ? limit_q : '0;
      end else begin
         step_val = dir_q ? (count_q - 1'b1) : (count_q + 1'b1);
      end

      if (stop) begin
         state_d  = ST_IDLE;
         reload_d = 1'b0;
      end else if (start) begin
         state_d  = ST_RUN;
         dir_d    = dir;
         count_d  = start_val;
         reload_d = 1'b0;
         // With limit 0 the start value is terminal in either direction.
         if (limit_q == '0) begin
            tc_d = 1'b1;
            if (auto_reload) begin
               reload_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end else if (state_q == ST_RUN && step_en) begin
         count_d  = step_val;
         reload_d = 1'b0;
         if (step_val == term_val) begin
            tc_d = 1'b1;
            if (auto_reload) begin
               reload_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         limit_q    <= '0;
         dir_q      <= 1'b0;
         reload_q   <= 1'b0;
         tc_q       <= 1'b0;
         trig_s1_q  <= 1'b0;
         trig_s2_q  <= 1'b0;
         trig_d_q   <= 1'b0;
         sync_vld_q <= 2'b00;
         arm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         limit_q    <= limit_d;
         dir_q      <= dir_d;
         reload_q   <= reload_d;
         tc_q       <= tc_d;
         trig_s1_q  <= trig_s1_d;
         trig_s2_q  <= trig_s2_d;
         trig_d_q   <= trig_d_d;
         sync_vld_q <= sync_vld_d;
         arm_q      <= arm_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_trig_counter_bidir.sv
`default_nettype none
// ============================================================================
// Module   : tb_trig_counter_bidir
// Desc     : Directed self-checking bench for trig_counter_bidir (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_trig_counter_bidir;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       we = 1'b0;
   logic       ld = 1'b0;
   logic       trig = 1'b0;
   logic       stop = 1'b0;
   logic       dir = 1'b0;
   logic       auto_reload = 1'b0;
   logic [7:0] tb_drv = 8'h00;
   logic       tb_drv_en = 1'b0;
   wire  [7:0] data_io;
   logic [7:0] count_o;
   logic       busy;
   logic       tc_pulse;

   int checks = 0;
   int errors = 0;

   assign data_io = tb_drv_en ? tb_drv : 8'bzzzz_zzzz;

   always #5 clk = ~clk;

   trig_counter_bidir #(.WIDTH(8), .PRESC_DIV(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_io    (data_io),
      .we         (we),
      .ld         (ld),
      .trig       (trig),
      .stop       (stop),
      .dir        (dir),
      .auto_reload(auto_reload),
      .count_o    (count_o),
      .busy       (busy),
      .tc_pulse   (tc_pulse)
   );

   typedef struct packed {
      logic       we;
      logic       ld;
      logic       trig;
      logic       stop;
      logic       dir;
      logic       ar;
      logic [7:0] drv;
      logic [7:0] e_cnt;
      logic       e_busy;
      logic       e_tc;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_limit(input logic [7:0] v);
      we        = 1'b0;
      tb_drv_en = 1'b1;
      tb_drv    = v;
      ld        = 1'b1;
      tick();
      chk("bus_in", {24'h0, data_io}, {24'h0, v});
      ld        = 1'b0;
      tb_drv_en = 1'b0;
      we        = 1'b1;
   endtask

   // Leaves the bench right after the edge on which the start takes effect.
   task automatic pulse_trig();
      trig = 1'b1;
      tick();
      trig = 1'b0;
      tick();
      tick();
   endtask

   task automatic chk_out(input string name, input logic [7:0] c, input logic b, input logic t);
      chk({name, "_cnt"},  {24'h0, count_o}, {24'h0, c});
      chk({name, "_busy"}, {31'h0, busy},    {31'h0, b});
      chk({name, "_tc"},   {31'h0, tc_pulse}, {31'h0, t});
   endtask

   initial begin
      // Up one-shot, limit 5: start lands on the third edge after trig rises.
      //            we    ld    trig  stop  dir   ar    drv    cnt    busy  tc
      tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 8'd0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b1, 1'b0};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd5, 1'b0, 1'b1};
      tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd5, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      chk_out("reset", 8'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (4) tick();

      for (int i = 0; i < 10; i++) begin
         we          = tbl[i].we;
         ld          = tbl[i].ld;
         trig        = tbl[i].trig;
         stop        = tbl[i].stop;
         dir         = tbl[i].dir;
         auto_reload = tbl[i].ar;
         tb_drv      = tbl[i].drv;
         tb_drv_en   = ~tbl[i].we;
         tick();
         chk_out($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_busy, tbl[i].e_tc);
         if (tbl[i].we) begin
            chk($sformatf("vec%0d_bus", i), {24'h0, data_io}, {24'h0, tbl[i].e_cnt});
         end
      end
      ld = 1'b0;

      // Down, auto-reload, limit 3: 3,2,1,0,3,2,...
      load_limit(8'd3);
      dir = 1'b1;
      auto_reload = 1'b1;
      pulse_trig();
      for (int k = 0; k < 10; k++) begin
         if (k > 0) tick();
         chk_out($sformatf("dn_ar%0d", k), 8'(3 - (k % 4)), 1'b1, ((k % 4) == 3));
      end
      stop = 1'b1;
      tick();
      chk_out("dn_ar_stop", 8'd2, 1'b0, 1'b0);
      stop = 1'b0;
      auto_reload = 1'b0;

      // Abort at 4, then stop coinciding with a start, then a lone start.
      load_limit(8'd10);
      dir = 1'b0;
      pulse_trig();
      repeat (4) tick();
      chk_out("abort_pre", 8'd4, 1'b1, 1'b0);
      stop = 1'b1;
      tick();
      chk_out("abort", 8'd4, 1'b0, 1'b0);
      pulse_trig();
      chk_out("stop_wins", 8'd4, 1'b0, 1'b0);
      stop = 1'b0;
      tick();
      pulse_trig();
      chk_out("restart", 8'd0, 1'b1, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;

      // Bus: load 0xA5, confirm via down start value.
      load_limit(8'hA5);
      dir = 1'b1;
      pulse_trig();
      chk_out("dn_start_a5", 8'hA5, 1'b1, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      dir = 1'b0;
      pulse_trig();
      repeat (7) tick();
      chk_out("up_at7", 8'd7, 1'b1, 1'b0);
      chk("bus_out7", {24'h0, data_io}, 32'h7);
      // Lower limit below the count: must wrap through 255 before hitting 2.
      we = 1'b0;
      tb_drv_en = 1'b1;
      tb_drv = 8'd2;
      ld = 1'b1;
      tick();
      chk_out("up_at8", 8'd8, 1'b1, 1'b0);
      ld = 1'b0;
      tb_drv_en = 1'b0;
      we = 1'b1;
      for (int v = 9; v <= 258; v++) begin
         tick();
         chk("wrap_cnt", {24'h0, count_o}, {24'h0, 8'(v)});
         chk("wrap_tc", {31'h0, tc_pulse}, {31'h0, (v == 258)});
         chk("wrap_busy", {31'h0, busy}, {31'h0, (v != 258)});
      end
      tick();
      chk_out("wrap_hold", 8'd2, 1'b0, 1'b0);

      // limit 0: terminal on the start edge, both directions.
      load_limit(8'd0);
      dir = 1'b0;
      pulse_trig();
      chk_out("lim0_up", 8'd0, 1'b0, 1'b1);
      tick();
      chk_out("lim0_up_after", 8'd0, 1'b0, 1'b0);
      dir = 1'b1;
      pulse_trig();
      chk_out("lim0_dn", 8'd0, 1'b0, 1'b1);

      // Restart by a new edge mid-run, then async reset with trig held high.
      load_limit(8'd10);
      dir = 1'b0;
      pulse_trig();
      repeat (3) tick();
      chk_out("run3", 8'd3, 1'b1, 1'b0);
      trig = 1'b1;
      tick();
      tick();
      chk_out("run5", 8'd5, 1'b1, 1'b0);
      tick();
      chk_out("rerun", 8'd0, 1'b1, 1'b0);
      tick();
      chk_out("rerun1", 8'd1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_out("async_rst", 8'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_out($sformatf("held%0d", k), 8'd0, 1'b0, 1'b0);
      end
      trig = 1'b0;
      repeat (3) tick();
      dir = 1'b0;
      pulse_trig();
      // Limit was cleared by reset, so the new start is terminal at once.
      chk_out("reedge", 8'd0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/trig_counter_bidir.md
Name: trig_counter_bidir

Overview:
- Parametrised up/down counter, started by an edge on a trigger input, with a shared bidirectional data port.
- data_io carries the limit value into the block when we=0. It carries the live count out when we=1.
- Limit is held in a proper register, loaded by strobe. The block adds a synchronised trigger, direction select, one-shot or auto-reload, abort, and a registered terminal-count pulse.
- Sits beside the existing counters as a general timer/event generator for control logic sharing one bus.

Parameters:
- WIDTH, 8, width of count, limit and data_io.
- PRESC_DIV, 4, prescale divide ratio (>=2); used only when PRESCALE_EN is defined.

Ports:
- clk  input  1  single system clock, all flops on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_io  inout  WIDTH  bidirectional; driven with count when we=1, high-Z when we=0.
- we  input  1  1 = block drives data_io; 0 = external driver owns data_io.
- ld  input  1  limit load strobe, honoured only when we=0.
- trig  input  1  asynchronous start request; a rising edge starts or restarts a run.
- stop  input  1  synchronous abort of the current run.
- dir  input  1  0 = count up 0->limit; 1 = count down limit->0; sampled at start.
- auto_reload  input  1  1 = periodic; 0 = one-shot; sampled every cycle.
- count_o  output  WIDTH  current count, always visible.
- busy  output  1  high while in RUN.
- tc_pulse  output  1  one-cycle registered terminal-count pulse.

Behaviour:
- Reset (rst_n=0, async): count=0, limit=0, state=IDLE, busy=0, tc_pulse=0, dir latch=0, sync flops=0, prescaler=0.
- data_io = we ? count : 'Z (combinational).
- Limit: at posedge with we=0 and ld=1, limit <= data_io. With we=1, ld is ignored. Limit may change during RUN; new value is used from the next compare.
- Trigger path: 2-flop synchroniser trig_s1/trig_s2, plus delay flop trig_d. start = trig_s2 & ~trig_d.
- Trigger timing: if trig is first sampled high at edge E0, start is valid after E1 and takes effect at E2.
- FSM states: IDLE, RUN.
- IDLE: count holds. On start, at the next edge:
  - state <= RUN, busy <= 1, dir latch <= dir.
  - count <= start value: 0 if up, limit if down.
- RUN, each step:
  - Up: count+1, modulo 2^WIDTH.
  - Down: count-1, modulo 2^WIDTH.
- Terminal value: limit if up, 0 if down. Compare is equality on the next-count value.
- On the edge count becomes the terminal value: tc_pulse <= 1 for exactly one cycle. Then:
  - auto_reload=0: state <= IDLE, busy <= 0; count holds the terminal value.
  - auto_reload=1: stay in RUN; the next step loads the start value instead of incrementing. Period = limit+1 steps.
- Count held at a value other than terminal in RUN (e.g. limit lowered below count while counting up): keep counting and wrap modulo 2^WIDTH until equality.
- limit=0 when the run starts:
  - Up: start value 0 is already terminal, so tc_pulse fires on the start edge. One-shot returns to IDLE there.
  - Down: identical behaviour.
- start while in RUN: restart. Count reloads the start value, dir is relatched, tc_pulse is not raised unless the start value is terminal.
- stop=1: state <= IDLE, busy <= 0, count holds, no tc_pulse.
- stop and start on the same edge: stop wins, state stays IDLE.
- Reset mid-run: immediate return to reset values; a trig held high afterwards produces no start until it falls and rises again.

Optional Feature:
- Macro: PRESCALE_EN.
- Defined: an internal prescaler of clog2(PRESC_DIV) bits runs in RUN. Count steps only when the prescaler reaches PRESC_DIV-1, then the prescaler wraps to 0. The prescaler clears on start, stop and entry to IDLE. tc_pulse stays one clk wide.
- Undefined: count steps every clk in RUN; PRESC_DIV is unused; no prescaler logic is present.

Test Plan:
- Up one-shot: WIDTH=8, load limit=5 (we=0, ld=1), then we=1, dir=0, auto_reload=0, pulse trig -> busy rises at E2, count_o/data_io show 0,1,2,3,4,5, tc_pulse is high for the single cycle with count=5, busy falls on the same edge, count holds at 5.
- Down auto-reload: limit=3, dir=1, auto_reload=1 -> count runs 3,2,1,0,3,2,1,0…, tc_pulse every 4 cycles, busy stays 1.
- Abort and restart: limit=10, up, stop asserted at count=4 -> IDLE, count=4, no tc_pulse. Stop and a trig edge arriving together -> stays IDLE. A later lone trig edge -> restarts from 0.
- Bus direction: we=0 with the bench driving 0xA5 and ld=1 -> limit=0xA5, DUT data_io is Z. we=1 -> data_io equals count_o, bench releases. Lower limit to 2 while counting up at 7 -> count wraps through 255->0 and pulses at 2.
- Edge cases: limit=0 gives tc_pulse on the start edge. Async rst_n low mid-run clears all outputs immediately. trig held high through reset gives no start until it is re-edged.
- PRESCALE_EN, PRESC_DIV=4, limit=2, up -> count changes every 4 clk (0..2 over 8 clk after start), tc_pulse is 1 clk wide.
